// File: rtl/binary_frame_capture.sv
// -----------------------------------------------------------------------------
// binary_frame_capture
//
// Thresholds a VGA pixel stream into 1-bit dark/light pixels and packs them,
// MSB first, into WORD_W-bit words for a simple dual-port image RAM.
// An IDLE -> WAIT_VS -> CAPTURE -> DONE machine captures one frame per arm
// (or every frame when continuous is set) and reports the frame's dark-pixel
// count.
//
// Ports
//   VGA_CLK        pixel clock
//   reset          synchronous, active-high
//   iVGA_R/G/B     8-bit pixel colour
//   iVGA_HS        horizontal sync (not used)
//   iVGA_VS        vertical sync, low between frames
//   iVGA_BLANK_N   high during active pixels
//   threshold      brightness cutoff, latched at frame start
//   chan_mask      {R,G,B} channels that must be below threshold, latched
//   invert         invert stored pixel polarity, latched
//   arm            request capture of the next frame (IDLE only)
//   continuous     re-arm automatically after each frame
//   wr_en          RAM write strobe, one cycle per word
//   wr_addr        RAM word address (holds between writes)
//   wr_data        packed pixels (holds between writes)
//   busy           high while waiting for or capturing a frame
//   frame_done     one-cycle pulse at the end of a captured frame
//   dark_count     dark pixels in the last completed frame
// -----------------------------------------------------------------------------
module binary_frame_capture #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned WORD_W = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 19
) (
  input  logic              VGA_CLK,
  input  logic              reset,
  input  logic [7:0]        iVGA_R,
  input  logic [7:0]        iVGA_G,
  input  logic [7:0]        iVGA_B,
  input  logic              iVGA_HS,
  input  logic              iVGA_VS,
  input  logic              iVGA_BLANK_N,
  input  logic [7:0]        threshold,
  input  logic [2:0]        chan_mask,
  input  logic              invert,
  input  logic              arm,
  input  logic              continuous,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  dark_count
);

  // Words per line and counter widths; x and y saturate one past the
  // captured window so out-of-window pixels/lines never wrap back in.
  localparam int unsigned WPL  = WIDTH / WORD_W;
  localparam int unsigned X_W  = $clog2(WIDTH + 1);
  localparam int unsigned Y_W  = $clog2(HEIGHT + 1);
  localparam int unsigned B_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned WI_W = $clog2(WPL + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // Frame configuration, frozen for the whole frame
  logic [7:0]        thr_q;
  logic [2:0]        mask_q;
  logic              inv_q;

  // Position and packing state
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [B_W-1:0]    bpos_q;
  logic [WI_W-1:0]   widx_q;
  logic [ADDR_W-1:0] base_q;
  logic [WORD_W-1:0] acc_q;
  logic [CNT_W-1:0]  count_q;

  // Previous-cycle sync levels for edge detection
  logic              blank_q;
  logic              vs_q;

  // Combinational control
  logic              dark_c;
  logic              pix_bit_c;
  logic              in_range_c;
  logic              start_c;
  logic              store_c;
  logic              word_full_c;
  logic              line_fall_c;
  logic              vs_fall_c;
  logic              pending_c;
  logic              write_c;
  logic [WORD_W-1:0] acc_set_c;

  // Horizontal sync carries no information the capture needs
  logic unused_hs;
  assign unused_hs = iVGA_HS;

  // Dark when every enabled channel is strictly below the threshold
  assign dark_c = (mask_q != 3'b000)
               && (!mask_q[2] || (iVGA_R < thr_q))
               && (!mask_q[1] || (iVGA_G < thr_q))
               && (!mask_q[0] || (iVGA_B < thr_q));

  assign pix_bit_c  = dark_c ^ inv_q;
  assign in_range_c = (x_q < X_W'(WIDTH)) && (y_q < Y_W'(HEIGHT));

  // Current word with the incoming pixel placed at its bit position
  always_comb begin
    acc_set_c = acc_q;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      if (bpos_q == B_W'(i)) begin
        acc_set_c[WORD_W-1-i] = pix_bit_c;
      end
    end
  end

  // State register
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and capture control
  always_comb begin
    state_d     = state_q;
    start_c     = 1'b0;
    store_c     = 1'b0;
    word_full_c = 1'b0;
    line_fall_c = 1'b0;
    vs_fall_c   = 1'b0;
    pending_c   = 1'b0;
    write_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_WAIT_VS;
        end
      end

      S_WAIT_VS: begin
        if (!iVGA_VS) begin
          state_d = S_CAPTURE;
          start_c = 1'b1;
        end
      end

      S_CAPTURE: begin
        store_c     = iVGA_BLANK_N && in_range_c;
        word_full_c = store_c && (bpos_q == B_W'(WORD_W - 1));
        line_fall_c = blank_q && !iVGA_BLANK_N;
        vs_fall_c   = vs_q && !iVGA_VS;
        // Bits left in the accumulator after this cycle's pixel
        pending_c   = store_c ? !word_full_c : (bpos_q != '0);
        // Full words always go out; partial words only when the line or
        // the frame is cut short
        write_c     = word_full_c || ((line_fall_c || vs_fall_c) && pending_c);

        if ((word_full_c && (y_q == Y_W'(HEIGHT - 1)) && (widx_q == WI_W'(WPL - 1)))
            || (line_fall_c && (y_q == Y_W'(HEIGHT - 1)))
            || vs_fall_c) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = continuous ? S_WAIT_VS : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      dark_count <= '0;
      thr_q      <= '0;
      mask_q     <= '0;
      inv_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      bpos_q     <= '0;
      widx_q     <= '0;
      base_q     <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      blank_q    <= 1'b0;
      vs_q       <= 1'b0;
    end else begin
      vs_q       <= iVGA_VS;
      wr_en      <= write_c;
      frame_done <= (state_q == S_DONE);
      busy       <= (state_d == S_WAIT_VS) || (state_d == S_CAPTURE);

      // Word data includes this cycle's pixel when one was stored
      if (write_c) begin
        wr_addr <= base_q + ADDR_W'(widx_q);
        wr_data <= store_c ? acc_set_c : acc_q;
      end

      if (state_q == S_DONE) begin
        dark_count <= count_q;
      end

      if (start_c) begin
        // New frame: clear position/packing, freeze configuration
        thr_q   <= threshold;
        mask_q  <= chan_mask;
        inv_q   <= invert;
        x_q     <= '0;
        y_q     <= '0;
        bpos_q  <= '0;
        widx_q  <= '0;
        base_q  <= '0;
        acc_q   <= '0;
        count_q <= '0;
        blank_q <= 1'b0;
      end else if (state_q == S_CAPTURE) begin
        blank_q <= iVGA_BLANK_N;

        if (line_fall_c) begin
          // End of line: next line starts a fresh word at the next row base
          x_q    <= '0;
          bpos_q <= '0;
          widx_q <= '0;
          acc_q  <= '0;
          base_q <= base_q + ADDR_W'(WPL);
          if (y_q != Y_W'(HEIGHT)) begin
            y_q <= y_q + 1'b1;
          end
        end else if (iVGA_BLANK_N) begin
          if (x_q != X_W'(WIDTH)) begin
            x_q <= x_q + 1'b1;
          end
          if (store_c) begin
            if (word_full_c) begin
              bpos_q <= '0;
              widx_q <= widx_q + 1'b1;
              acc_q  <= '0;
            end else begin
              bpos_q <= bpos_q + 1'b1;
              acc_q  <= acc_set_c;
            end
            if (dark_c && (count_q != '1)) begin
              count_q <= count_q + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
